// File: rtl/rca.sv
`default_nettype none
// ============================================================================
// Module   : rca
// Purpose  : Parameterised ripple-carry adder built from per-bit full-adder
//            stages, with registered sum, carry-out and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================

module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

module rca #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_0,
  output logic [WIDTH-1:0] sum,
  output logic             c_4,
  output logic             ovf
);
  // w_carry[i] is the carry into stage i; w_carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_carry[0] = c_0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    rca_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (w_sum[i]),
      .co (w_carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      c_4 <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sum <= w_sum;
      c_4 <= w_carry[WIDTH];
      ovf <= w_ovf;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_rca.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca
// Purpose  : Self-checking bench for rca (WIDTH=4) against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rca;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_0;
  logic [WIDTH-1:0] sum;
  logic             c_4;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  rca #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c_0 (c_0),
    .sum (sum),
    .c_4 (c_4),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  // Reference: unsigned total gives {carry, sum}; signed total gives overflow.
  function automatic logic [WIDTH+1:0] model(input int ua, input int ub, input int uc);
    int total;
    int sa;
    int sb;
    int st;
    logic [WIDTH+1:0] res;
    total = ua + ub + uc;
    sa = (ua >= (1 << (WIDTH-1))) ? ua - (1 << WIDTH) : ua;
    sb = (ub >= (1 << (WIDTH-1))) ? ub - (1 << WIDTH) : ub;
    st = sa + sb + uc;
    res[WIDTH:0]   = total[WIDTH:0];
    res[WIDTH+1]   = (st > (1 << (WIDTH-1)) - 1) || (st < -(1 << (WIDTH-1)));
    return res;
  endfunction

  task automatic test_reset();
    rst = 1'b1; a = 4'hF; b = 4'hF; c_0 = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if ({ovf, c_4, sum} !== 6'b0) begin
        errors++;
        $display("FAIL reset_edge%0d got ovf=%0b c_4=%0b sum=%h want all 0", e, ovf, c_4, sum);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ovf, c_4, sum} !== {1'b0, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL reset_release got ovf=%0b c_4=%0b sum=%h want ovf=0 c_4=1 sum=f", ovf, c_4, sum);
    end
  endtask

  task automatic test_directed();
    // {a, b, c_0, expected ovf, c_4, sum}
    logic [14:0] vec [6];
    vec[0] = {4'b0100, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1110};
    vec[1] = {4'b0110, 4'b1011, 1'b1, 1'b0, 1'b1, 4'b0010};
    vec[2] = {4'b0111, 4'b1100, 1'b0, 1'b0, 1'b1, 4'b0011};
    vec[3] = {4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000};
    vec[4] = {4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b1000};
    vec[5] = {4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      a = vec[i][14:11]; b = vec[i][10:7]; c_0 = vec[i][6];
      @(posedge clk); #1;
      checks++;
      if ({ovf, c_4, sum} !== vec[i][5:0]) begin
        errors++;
        $display("FAIL directed%0d got ovf=%0b c_4=%0b sum=%b want %b", i, ovf, c_4, sum, vec[i][5:0]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [WIDTH+1:0] exp;
    for (int i = 0; i < 512; i++) begin
      a = i[8:5]; b = i[4:1]; c_0 = i[0];
      rst = (i == 200);
      exp = rst ? '0 : model(int'(a), int'(b), int'(c_0));
      @(posedge clk); #1;
      checks++;
      if ({ovf, c_4, sum} !== exp) begin
        errors++;
        $display("FAIL sweep a=%h b=%h c_0=%0b rst=%0b got %b want %b", a, b, c_0, rst,
                 {ovf, c_4, sum}, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH+1:0] exp;
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_0 = 1'($urandom);
      exp = model(int'(a), int'(b), int'(c_0));
      @(posedge clk); #1;
      checks++;
      if ({ovf, c_4, sum} !== exp) begin
        errors++;
        $display("FAIL random a=%h b=%h c_0=%0b got %b want %b", a, b, c_0, {ovf, c_4, sum}, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; c_0 = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
